// File: rtl/mem_bus_ctrl_pkg.sv
// Shared definitions for the asynchronous-memory bus sequencer:
// FSM state encoding and word-alignment constants.
package mem_bus_ctrl_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SETUP   = 3'd1;
    localparam logic [2:0] ST_ACCESS  = 3'd2;
    localparam logic [2:0] ST_RECOVER = 3'd3;
    localparam logic [2:0] ST_RESP    = 3'd4;

    localparam int         BYTES_PER_WORD = 4;
    localparam logic [1:0] ALIGN_MASK     = 2'(BYTES_PER_WORD - 1);

    localparam int CNT_WIDTH = 4;

endpackage

// File: rtl/mem_bus_wait_cnt.sv
// Loadable down-counter with a zero flag; paces the chip-select
// window of each memory access.
module mem_bus_wait_cnt #(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_reg <= '0;
        end else if (i_load) begin
            count_reg <= i_load_value;
        end else if (i_dec && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign o_zero = (count_reg == '0);

endmodule

// File: rtl/mem_bus_ctrl.sv
// Word read/write sequencer for a byte-addressed asynchronous memory:
// setup / access / recover phases with registered pin drivers.
module mem_bus_ctrl
    import mem_bus_ctrl_pkg::*;
#(
    parameter int ADDRESS_SIZE  = 8,
    parameter int WORD_SIZE     = 32,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_req_valid,
    output logic                    o_req_ready,
    input  logic                    i_req_we,
    input  logic [ADDRESS_SIZE-1:0] i_req_addr,
    input  logic [WORD_SIZE-1:0]    i_req_wdata,
    output logic                    o_rsp_valid,
    input  logic                    i_rsp_ready,
    output logic [WORD_SIZE-1:0]    o_rsp_rdata,
    output logic                    o_rsp_err,
    output logic [ADDRESS_SIZE-1:0] o_mem_address,
    output logic [WORD_SIZE-1:0]    o_mem_data_in,
    output logic                    o_mem_cs,
    output logic                    o_mem_we,
    output logic                    o_mem_oe,
    input  logic [WORD_SIZE-1:0]    i_mem_data_out
);

    localparam logic [ADDRESS_SIZE:0] MAX_ADDR =
        (ADDRESS_SIZE + 1)'((1 << ADDRESS_SIZE) - BYTES_PER_WORD);
    localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(ACCESS_CYCLES - 1);

    logic [2:0]              state_reg, state_next;
    logic                    op_we_reg;
    logic [ADDRESS_SIZE-1:0] addr_reg;
    logic [WORD_SIZE-1:0]    wdata_reg;
    logic                    err_reg;

    logic                    req_accept, addr_bad, rsp_done;
    logic                    cnt_load, cnt_dec, cnt_zero;
    logic                    cs_next, we_next, oe_next, valid_next, err_next;
    logic [ADDRESS_SIZE-1:0] address_next;
    logic [WORD_SIZE-1:0]    data_in_next, rdata_next;

    assign req_accept = i_req_valid && o_req_ready;
    assign rsp_done   = o_rsp_valid && i_rsp_ready;
    assign addr_bad   = ((i_req_addr[1:0] & ALIGN_MASK) != 2'b00) ||
                        ({1'b0, i_req_addr} > MAX_ADDR);

    mem_bus_wait_cnt #(.WIDTH(CNT_WIDTH)) u_wait_cnt (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_load       (cnt_load),
        .i_load_value (CNT_LOAD),
        .i_dec        (cnt_dec),
        .o_zero       (cnt_zero)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg <= ST_IDLE;
            op_we_reg <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (req_accept) begin
                op_we_reg <= i_req_we;
                addr_reg  <= i_req_addr;
                wdata_reg <= i_req_wdata;
                err_reg   <= addr_bad;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:    if (req_accept) state_next = addr_bad ? ST_RESP : ST_SETUP;
            ST_SETUP:   state_next = ST_ACCESS;
            ST_ACCESS:  if (cnt_zero) state_next = ST_RECOVER;
            ST_RECOVER: state_next = ST_RESP;
            ST_RESP:    if (rsp_done) state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // Pin values are decoded from the current state and registered, so the
    // pins trail the state by one cycle and never glitch.
    always_comb begin
        o_req_ready  = (state_reg == ST_IDLE);
        cnt_load     = (state_reg == ST_SETUP);
        cnt_dec      = (state_reg == ST_ACCESS);
        cs_next      = (state_reg == ST_ACCESS);
        we_next      = (state_reg == ST_ACCESS) && op_we_reg;
        oe_next      = (state_reg == ST_ACCESS) && !op_we_reg;
        address_next = o_mem_address;
        data_in_next = o_mem_data_in;
        rdata_next   = o_rsp_rdata;
        valid_next   = 1'b0;
        err_next     = 1'b0;
        case (state_reg)
            ST_SETUP: begin
                address_next = addr_reg;
                data_in_next = op_we_reg ? wdata_reg : '0;
            end
            ST_RECOVER: begin
                // Last cycle of the CS window on the pins; read data is settled.
                if (!op_we_reg) rdata_next = i_mem_data_out;
            end
            ST_RESP: begin
                valid_next = !rsp_done;
                err_next   = !rsp_done && err_reg;
                if (rsp_done) begin
                    data_in_next = '0;
                    rdata_next   = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_mem_cs      <= 1'b0;
            o_mem_we      <= 1'b0;
            o_mem_oe      <= 1'b0;
            o_mem_address <= '0;
            o_mem_data_in <= '0;
            o_rsp_rdata   <= '0;
            o_rsp_valid   <= 1'b0;
            o_rsp_err     <= 1'b0;
        end else begin
            o_mem_cs      <= cs_next;
            o_mem_we      <= we_next;
            o_mem_oe      <= oe_next;
            o_mem_address <= address_next;
            o_mem_data_in <= data_in_next;
            o_rsp_rdata   <= rdata_next;
            o_rsp_valid   <= valid_next;
            o_rsp_err     <= err_next;
        end
    end

endmodule
